axis_credit_gater: RTL

Credit-based packet gate for AXI-Stream, the packet-wise successor to the simple pass/block gater. A control port deposits packet credits. Each credit admits exactly one whole packet. With no credit, the block either back-pressures the input or discards whole packets, depending on a build-time mode. It sits between a packet source and a rate- or permission-limited sink, for example a DMA egress or a host-released buffer. The data path is zero-latency.

---
 rtl/axis_credit_gater_if.sv | 14 +
 rtl/axis_credit_gater.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/axis_credit_gater_if.sv
// AXI-Stream bundle shared by the input and output sides of the credit gater.
interface axis_credit_gater_if #(
    parameter int BYTES     = 1,
    parameter int USER_BITS = 1
);
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [8*BYTES-1:0]     tdata;
    logic [USER_BITS-1:0]   tuser;

    modport master (output tvalid, output tlast, output tdata, output tuser, input tready);
    modport slave  (input tvalid, input tlast, input tdata, input tuser, output tready);
endinterface

// File: rtl/axis_credit_gater.sv
// Credit-based whole-packet gate for AXI-Stream. Each deposited credit admits
// one packet; with no credit the gate either stalls the source or discards
// whole packets. Payload is combinational pass-through, only the handshake is gated.
module axis_credit_gater #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int CREDIT_BITS    = 8,
    parameter int COUNT_BITS     = 16,
    parameter int DROP_MODE      = 0
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    c_valid,
    output logic                    c_ready,
    input  logic [CREDIT_BITS-1:0]  c_credits,
    input  logic                    c_clear,
    output logic [CREDIT_BITS-1:0]  credit,
    output logic [COUNT_BITS-1:0]   drop_count,
    output logic                    in_packet,
    axis_credit_gater_if.slave      axis_i,
    axis_credit_gater_if.master     axis_o
);

    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;
    localparam logic [COUNT_BITS-1:0]  COUNT_MAX  = '1;
    localparam bit                     DROP_EN    = (DROP_MODE != 0);

    typedef enum logic [1:0] {
        SM_IDLE = 2'd0,
        SM_PASS = 2'd1,
        SM_DROP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CREDIT_BITS-1:0]  r_credit;
    logic [CREDIT_BITS-1:0]  w_credit_nxt;
    logic [CREDIT_BITS:0]    w_credit_sum;
    logic [COUNT_BITS-1:0]   r_drop_count;
    logic [COUNT_BITS-1:0]   w_drop_nxt;
    logic                    w_has_credit;
    logic                    w_o_tvalid;
    logic                    w_i_tready;
    logic                    w_in_hs;
    logic                    w_deposit;
    logic                    w_consume;
    logic                    w_drop_first;

    // Payload fields are never gated.
    assign axis_o.tdata = axis_i.tdata[8*AXIS_BYTES-1:0];
    assign axis_o.tuser = axis_i.tuser[AXIS_USER_BITS-1:0];
    assign axis_o.tlast = axis_i.tlast;

    assign w_has_credit = (r_credit != '0);
    assign w_in_hs      = axis_i.tvalid && w_i_tready;
    assign w_deposit    = c_valid && c_ready;
    assign w_consume    = (r_state == SM_IDLE) && w_has_credit && w_in_hs;
    assign w_drop_first = DROP_EN && (r_state == SM_IDLE) && !w_has_credit && w_in_hs;

    assign c_ready      = (r_credit != CREDIT_MAX);
    assign credit       = r_credit;
    assign drop_count   = r_drop_count;
    assign in_packet    = (r_state != SM_IDLE);
    assign axis_o.tvalid = w_o_tvalid;
    assign axis_i.tready = w_i_tready;

    // State register: reset lands at a packet boundary.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= SM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave IDLE on a non-last first beat, return on the last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SM_IDLE: begin
                if (w_in_hs && !axis_i.tlast) begin
                    if (w_has_credit) begin
                        w_state_nxt = SM_PASS;
                    end else if (DROP_EN) begin
                        w_state_nxt = SM_DROP;
                    end
                end
            end
            SM_PASS, SM_DROP: begin
                if (w_in_hs && axis_i.tlast) begin
                    w_state_nxt = SM_IDLE;
                end
            end
            default: w_state_nxt = SM_IDLE;
        endcase
    end

    // Handshake gating: pass-through, stall, or sink depending on state and credit.
    always_comb begin
        w_o_tvalid = 1'b0;
        w_i_tready = 1'b0;
        case (r_state)
            SM_IDLE: begin
                if (w_has_credit) begin
                    w_o_tvalid = axis_i.tvalid;
                    w_i_tready = axis_o.tready;
                end else if (DROP_EN) begin
                    w_i_tready = 1'b1;
                end
            end
            SM_PASS: begin
                w_o_tvalid = axis_i.tvalid;
                w_i_tready = axis_o.tready;
            end
            SM_DROP: begin
                w_i_tready = 1'b1;
            end
            default: begin
                w_o_tvalid = 1'b0;
                w_i_tready = 1'b0;
            end
        endcase
    end

    // Credit next value: one extra bit catches overflow before saturation; clear wins.
    always_comb begin
        w_credit_sum = {1'b0, r_credit}
                     - {{CREDIT_BITS{1'b0}}, w_consume}
                     + (w_deposit ? {1'b0, c_credits} : {(CREDIT_BITS+1){1'b0}});
        if (c_clear) begin
            w_credit_nxt = '0;
        end else if (w_credit_sum[CREDIT_BITS]) begin
            w_credit_nxt = CREDIT_MAX;
        end else begin
            w_credit_nxt = w_credit_sum[CREDIT_BITS-1:0];
        end
    end

    // Drop counter next value: saturating count of discarded packets.
    always_comb begin
        w_drop_nxt = r_drop_count;
        if (w_drop_first && (r_drop_count != COUNT_MAX)) begin
            w_drop_nxt = r_drop_count + COUNT_BITS'(1);
        end
    end

    // Credit and drop-count registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_credit     <= '0;
            r_drop_count <= '0;
        end else begin
            r_credit     <= w_credit_nxt;
            r_drop_count <= w_drop_nxt;
        end
    end

endmodule
